// File: rtl/nlprg_pkg.sv
// Shared definitions for the 13-bit nonlinear pattern generator and its checker.
package nlprg_pkg;

  localparam int unsigned NLPRG_N = 13;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } chk_state_e;

  // One generator step: a left-shifting Fibonacci LFSR on x^13+x^4+x^3+x+1.
  // The extra NOR term splices the all-zero word into the cycle, which
  // gives a full 2^13-word period that contains exactly one zero word.
  function automatic logic [NLPRG_N-1:0] nlprg_next(input logic [NLPRG_N-1:0] s);
    logic fb;
    fb = s[12] ^ s[3] ^ s[2] ^ s[0] ^ (s[11:0] == '0);
    return {s[11:0], fb};
  endfunction

endpackage

// File: rtl/nlprg_period_mon.sv
// Period monitor: measures the distance between successive matched zero words
// while the checker is locked.
module nlprg_period_mon
  import nlprg_pkg::*;
#(
  parameter int unsigned N = NLPRG_N
) (
  input  logic ck_i,
  input  logic rst_i,
  input  logic word_vld_i,   // valid word processed in LOCK
  input  logic word_hit_i,   // that word matched the flywheel
  input  logic word_zero_i,  // that word is all zeros
  input  logic clear_i,      // checker is leaving LOCK
  output logic period_ok_o,
  output logic period_err_o
);

  localparam logic [N:0] PER_FULL = {1'b0, {N{1'b1}}};

  logic [N:0] per_q, per_d;
  logic       seen_q, seen_d;
  logic       ok_q, ok_d;
  logic       perr_q, perr_d;

  // Next-state for the distance counter and the period pulses.
  always_comb begin
    per_d  = per_q;
    seen_d = seen_q;
    ok_d   = 1'b0;
    perr_d = 1'b0;
    if (clear_i) begin
      per_d  = '0;
      seen_d = 1'b0;
    end else if (word_vld_i) begin
      if (word_hit_i && word_zero_i) begin
        if (seen_q) begin
          ok_d   = (per_q == PER_FULL);
          perr_d = (per_q != PER_FULL);
        end
        per_d  = '0;
        seen_d = 1'b1;
      end else if (per_q != '1) begin
        per_d = per_q + 1'b1;
      end
    end
  end

  // Registered counter state and pulses.
  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      per_q  <= '0;
      seen_q <= 1'b0;
      ok_q   <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      per_q  <= per_d;
      seen_q <= seen_d;
      ok_q   <= ok_d;
      perr_q <= perr_d;
    end
  end

  assign period_ok_o  = ok_q;
  assign period_err_o = perr_q;

endmodule

// File: rtl/nlprg13_chk.sv
// Checker for the nlprg13 generator stream: acquires lock, flywheels the
// expected sequence, counts locked mismatches and monitors the period.
module nlprg13_chk
  import nlprg_pkg::*;
#(
  parameter int unsigned N          = NLPRG_N,
  parameter int unsigned SYNC_WORDS = 4,
  parameter int unsigned LOSS_ERRS  = 3
) (
  input  logic         ck,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         din_vld,
  output logic         lock,
  output logic         err,
  output logic [15:0]  err_cnt,
  output logic         period_ok,
  output logic         period_err
);

  localparam int unsigned   MW        = $clog2(SYNC_WORDS + 1);
  localparam int unsigned   LW        = $clog2(LOSS_ERRS + 1);
  localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_WORDS - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_ERRS - 1);

  chk_state_e    state_q, state_d;
  logic [N-1:0]  exp_q, exp_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic          err_q, err_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          lock_q;
  logic          hit;
  logic          din_zero;
  logic          mon_word;
  logic          leave_lock;

  assign hit      = (din == exp_q);
  assign din_zero = (din == '0);

  // Acquisition / flywheel FSM next-state and counter updates.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    mon_word   = 1'b0;
    leave_lock = 1'b0;
    if (din_vld) begin
      case (state_q)
        HUNT: begin
          exp_d   = nlprg_next(din);
          match_d = '0;
          state_d = SYNC;
        end
        SYNC: begin
          exp_d = nlprg_next(din);
          if (hit) begin
            match_d = match_q + 1'b1;
            if (match_q == SYNC_LAST) state_d = LOCK;
          end else begin
            match_d = '0;
          end
        end
        LOCK: begin
          exp_d    = nlprg_next(exp_q);
          mon_word = 1'b1;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            miss_d = miss_q + 1'b1;
            if (miss_q == LOSS_LAST) begin
              state_d    = HUNT;
              miss_d     = '0;
              leave_lock = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers; lock tracks the state being entered.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      lock_q    <= (state_d == LOCK);
    end
  end

  nlprg_period_mon #(
    .N(N)
  ) u_period (
    .ck_i        (ck),
    .rst_i       (rst),
    .word_vld_i  (mon_word),
    .word_hit_i  (hit),
    .word_zero_i (din_zero),
    .clear_i     (leave_lock),
    .period_ok_o (period_ok),
    .period_err_o(period_err)
  );

  assign lock    = lock_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_nlprg13_chk.sv
// Self-checking bench for nlprg13_chk: vector table, directed corner cases
// and a randomized stream compared against a behavioural reference model.
module tb_nlprg13_chk;

  localparam int PERIOD_GAP = (1 << 13) - 1;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] din = '0;
  logic        din_vld = 1'b0;
  logic        lock, err, period_ok, period_err;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;

  nlprg13_chk #(
    .N(13),
    .SYNC_WORDS(4),
    .LOSS_ERRS(3)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .lock      (lock),
    .err       (err),
    .err_cnt   (err_cnt),
    .period_ok (period_ok),
    .period_err(period_err)
  );

  always #5 ck = ~ck;

  // Generator step written from the recurrence: parity of the tapped bits,
  // inverted when the low twelve bits are all zero (zero-word insertion).
  function automatic logic [12:0] gen_next(input logic [12:0] s);
    logic fb;
    fb = ^(s & 13'h100D);
    if ((s & 13'h0FFF) == 13'h0) fb = ~fb;
    return {s[11:0], fb};
  endfunction

  // Reference model state.
  bit          m_lock, m_track, m_seen;
  int          m_run, m_miss, m_per, m_cnt;
  logic [12:0] m_exp;
  bit          m_err, m_pok, m_perr;

  logic [12:0] g;  // generator state of the transmitted stream

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_track = 0; m_seen = 0;
    m_run = 0; m_miss = 0; m_per = 0; m_cnt = 0;
    m_exp = '0; m_err = 0; m_pok = 0; m_perr = 0;
  endtask

  task automatic model_step(input bit vld, input logic [12:0] w);
    bit hit;
    m_err = 0; m_pok = 0; m_perr = 0;
    if (!vld) return;
    if (!m_lock) begin
      if (m_track && w == m_exp) begin
        m_run++;
        if (m_run == 4) begin
          m_lock = 1; m_miss = 0; m_per = 0; m_seen = 0;
        end
      end else begin
        m_run = 0;
      end
      m_track = 1;
      m_exp = gen_next(w);
    end else begin
      hit = (w == m_exp);
      m_exp = gen_next(m_exp);
      if (!hit) begin
        m_err = 1;
        if (m_cnt < 65535) m_cnt++;
        m_miss++;
        if (m_per < 16383) m_per++;
        if (m_miss == 3) begin
          m_lock = 0; m_track = 0; m_miss = 0; m_per = 0; m_seen = 0;
        end
      end else begin
        m_miss = 0;
        if (w == 13'h0) begin
          if (m_seen) begin
            if (m_per == PERIOD_GAP) m_pok = 1;
            else m_perr = 1;
          end
          m_per = 0;
          m_seen = 1;
        end else if (m_per < 16383) begin
          m_per++;
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("model_lock", 32'(lock), 32'(m_lock));
    chk("model_err", 32'(err), 32'(m_err));
    chk("model_err_cnt", 32'(err_cnt), m_cnt);
    chk("model_period_ok", 32'(period_ok), 32'(m_pok));
    chk("model_period_err", 32'(period_err), 32'(m_perr));
  endtask

  // One clock: drive at negedge, sample 1ns after the rising edge.
  task automatic send(input bit vld, input bit corrupt);
    logic [12:0] w;
    w = vld ? (g ^ 13'(corrupt)) : 13'($urandom);
    @(negedge ck);
    rst = 1'b0;
    din = w;
    din_vld = vld;
    @(posedge ck);
    #1;
    model_step(vld, w);
    if (vld) g = gen_next(g);
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge ck);
    rst = 1'b1;
    din_vld = 1'b1;  // reset must win over a valid word
    din = 13'($urandom);
    @(posedge ck);
    #1;
    model_reset();
    chk("rst_lock", 32'(lock), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_period_ok", 32'(period_ok), 0);
    chk("rst_period_err", 32'(period_err), 0);
  endtask

  typedef struct {
    bit vld;
    bit corrupt;
    bit lock;
    bit err;
    int cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int zl, okc, pec, burst;
    bit v, c;

    tbl[0]  = '{1, 0, 0, 0, 0};  // HUNT -> SYNC
    tbl[1]  = '{0, 0, 0, 0, 0};  // gap ignored
    tbl[2]  = '{1, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 0, 0};  // fourth match -> LOCK
    tbl[7]  = '{1, 1, 1, 1, 1};
    tbl[8]  = '{1, 0, 1, 0, 1};
    tbl[9]  = '{1, 1, 1, 1, 2};
    tbl[10] = '{1, 0, 1, 0, 2};
    tbl[11] = '{1, 1, 1, 1, 3};
    tbl[12] = '{1, 1, 1, 1, 4};
    tbl[13] = '{1, 1, 0, 1, 5};  // third consecutive miss drops lock
    tbl[14] = '{1, 0, 0, 0, 5};

    do_reset();
    g = 13'($urandom_range(8191, 1));
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].vld, tbl[i].corrupt);
      chk("tbl_lock", 32'(lock), 32'(tbl[i].lock));
      chk("tbl_err", 32'(err), 32'(tbl[i].err));
      chk("tbl_err_cnt", 32'(err_cnt), tbl[i].cnt);
    end

    // Clean stream with random gaps: lock within 6 words, period pulses.
    do_reset();
    zl = 0; okc = 0; pec = 0;
    for (int i = 0; i < 20000; ) begin
      if ($urandom_range(9) == 0) begin
        send(0, 0);
      end else begin
        if (i >= 5 && g == 13'h0) zl++;
        send(1, 0);
        if (i == 5) chk("lock_within_6", 32'(lock), 1);
        i++;
      end
      if (period_ok) okc++;
      if (period_err) pec++;
    end
    chk("clean_period_ok_count", okc, (zl > 0) ? zl - 1 : 0);
    chk("clean_period_err_count", pec, 0);
    chk("clean_err_cnt", 32'(err_cnt), 0);

    // Seven idle cycles in a locked stream, generator held.
    for (int i = 0; i < 7; i++) begin
      send(0, 0);
      chk("idle_err", 32'(err), 0);
      chk("idle_lock", 32'(lock), 1);
    end
    send(1, 0);
    chk("after_idle_err", 32'(err), 0);

    // Single flipped bit while locked.
    send(1, 1);
    chk("flip_err", 32'(err), 1);
    chk("flip_err_cnt", 32'(err_cnt), 1);
    chk("flip_lock", 32'(lock), 1);
    send(1, 0);
    chk("flip_next_err", 32'(err), 0);
    chk("flip_next_lock", 32'(lock), 1);

    // Three consecutive corrupt words drop lock; five clean words relock.
    do_reset();
    for (int i = 0; i < 5; i++) send(1, 0);
    chk("relock_pre", 32'(lock), 1);
    for (int i = 0; i < 3; i++) send(1, 1);
    chk("burst_err_cnt", 32'(err_cnt), 3);
    chk("burst_lock", 32'(lock), 0);
    for (int i = 0; i < 4; i++) send(1, 0);
    chk("relock_4", 32'(lock), 0);
    send(1, 0);
    chk("relock_5", 32'(lock), 1);

    // Reset while locked with err_cnt=2.
    send(1, 1);
    send(1, 0);
    send(1, 1);
    send(1, 0);
    chk("pre_rst_err_cnt", 32'(err_cnt), 5);
    do_reset();
    for (int i = 0; i < 5; i++) send(1, 0);
    send(1, 1);
    send(1, 0);
    send(1, 1);
    chk("err_cnt_two", 32'(err_cnt), 2);
    do_reset();
    chk("rst_lock_drop", 32'(lock), 0);
    for (int i = 0; i < 4; i++) send(1, 0);
    chk("post_rst_hunt", 32'(lock), 0);
    send(1, 0);
    chk("post_rst_lock", 32'(lock), 1);

    // Randomized stream with scattered errors and occasional bursts.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(4) != 0);
      if (burst == 0 && $urandom_range(199) == 0) burst = 3;
      c = (burst > 0) || ($urandom_range(39) == 0);
      if (v && burst > 0) burst--;
      send(v, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nlprg13_chk.md
NLPRG13_CHK -- requirements
Module: nlprg13_chk

Interface
REQ-001 Parameter N, default 13: word width of the checked generator.
REQ-002 Parameter SYNC_WORDS, default 4: consecutive matches needed to declare lock.
REQ-003 Parameter LOSS_ERRS, default 3: consecutive mismatches that drop lock.
REQ-004 Port ck  input  1: single clock; all state on rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port din  input  N: received generator word.
REQ-007 Port din_vld  input  1: din valid this cycle; words with din_vld=0 are ignored.
REQ-008 Port lock  output  1: checker locked to the sequence.
REQ-009 Port err  output  1: one-cycle pulse, mismatch while locked.
REQ-010 Port err_cnt  output  16: count of locked mismatches, saturating at 16'hFFFF.
REQ-011 Port period_ok  output  1: one-cycle pulse, zero word recurred after exactly 2^N-1 intervening words.
REQ-012 Port period_err  output  1: one-cycle pulse, zero word recurred at any other distance.

Function
REQ-013 Next-state function SHALL be nlprg_next(N-bit), bit-identical to the nlprg13 generator step.
REQ-014 FSM states SHALL be HUNT, SYNC, LOCK; all transitions occur only on cycles with din_vld=1.
REQ-015 HUNT: on valid word, expected <= nlprg_next(din), match_cnt <= 0, go SYNC.
REQ-016 SYNC, din==expected: match_cnt++, expected <= nlprg_next(din); when match_cnt reaches SYNC_WORDS go LOCK.
REQ-017 SYNC, din!=expected: reseed expected <= nlprg_next(din), match_cnt <= 0, stay SYNC; no err pulse.
REQ-018 LOCK: expected <= nlprg_next(expected) on every valid word (flywheel, never reseeds from din).
REQ-019 LOCK, mismatch: err=1 next cycle, err_cnt++ (saturating), miss_cnt++; at miss_cnt==LOSS_ERRS go HUNT.
REQ-020 LOCK, match: miss_cnt <= 0.
REQ-021 lock SHALL be 1 exactly while state==LOCK, registered; it asserts the cycle after the SYNC_WORDS-th match.
REQ-022 All outputs SHALL be registered; err/period pulses appear one cycle after the sampling edge of the word.
REQ-023 Period tracking only in LOCK: on a matched word equal to 0, if zero_seen then per_cnt==2^N-1 gives period_ok, otherwise period_err; then per_cnt <= 0, zero_seen <= 1.
REQ-024 per_cnt (N+1 bits) increments on every other valid word in LOCK and saturates at all-ones.
REQ-025 A mismatched word does not count as a zero word; it still increments per_cnt.
REQ-026 Leaving LOCK SHALL clear zero_seen, per_cnt, miss_cnt; err_cnt is retained.
REQ-027 din_vld=0 for any number of cycles SHALL freeze all state; pulses stay 0.

Reset
REQ-028 Under rst=1 at a rising edge: state=HUNT, lock=0, err=0, err_cnt=0, period_ok=0, period_err=0, expected=0, match_cnt=0, miss_cnt=0, per_cnt=0, zero_seen=0.
REQ-029 rst SHALL dominate din_vld in the same cycle; reset mid-LOCK drops lock the next cycle.

Structure
REQ-030 Shared package nlprg_pkg SHALL hold nlprg_next, the state enumeration and the default N; the generator uses the same function.
REQ-031 One sub-module, nlprg_period_mon (per_cnt, zero_seen, period pulses), is natural; the FSM and compare stay in nlprg13_chk.

Verification
REQ-032 Bench SHALL drive nlprg13 output straight into din with din_vld=1 after reset -> lock=1 within 6 words, err_cnt stays 0.
REQ-033 Clean stream for 20000 words -> period_ok pulses at each zero word after the first, period_err never pulses.
REQ-034 Once locked, flip bit 0 of a single word -> one err pulse, err_cnt=1, lock stays 1, next word matches.
REQ-035 Once locked, corrupt 3 consecutive words -> err_cnt=3, lock=0 on cycle after third, relock after 5 clean words.
REQ-036 Deassert din_vld for 7 random cycles in a locked stream (generator held) -> no err, lock stays 1.
REQ-037 Assert rst for one cycle while locked with err_cnt=2 -> next cycle lock=0, err_cnt=0, state HUNT.
